// File: rtl/riscv_uop_pkg.sv
// rtl/riscv_uop_pkg.sv - uop type and issue-channel definitions shared by ISSUE and the dispatch buffer
package riscv_uop_pkg;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       rd_wr;
  } uop_t;

  typedef enum logic [0:0] {
    ISSUE_CH_ALU = 1'b0,
    ISSUE_CH_LSU = 1'b1
  } issue_ch_e;

  localparam int ISSUE_NUM_CH = 2;
  localparam int ISSUE_DATA_W = 32;

  // Reference layout; parametrised users pack the same field order at their own DATA_W.
  typedef struct packed {
    uop_t                    uop;
    logic [31:0]             pc;
    logic [ISSUE_DATA_W-1:0] op1;
    logic [ISSUE_DATA_W-1:0] op2;
  } issue_entry_t;

endpackage

// File: rtl/issue_dispatch_buffer_ch_fifo.sv
// rtl/issue_dispatch_buffer_ch_fifo.sv - per-channel FIFO (module issue_ch_fifo) with flush and registered count
module issue_ch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_pop;

  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr[AW-1:0]];

  // Storage is not reset; validity comes only from the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/issue_dispatch_buffer.sv
// rtl/issue_dispatch_buffer.sv - multi-channel issue buffer steering uops to per-FU FIFOs; optional ISSUE_BYPASS_EN
module issue_dispatch_buffer
  import riscv_uop_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  localparam int CH_W  = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           s_valid,
  input  logic [CH_W-1:0]                s_ch,
  input  uop_t                           s_uop,
  input  logic [31:0]                    s_pc,
  input  logic [DATA_W-1:0]              s_op1,
  input  logic [DATA_W-1:0]              s_op2,
  output logic                           s_ready,
  output logic [NUM_CH-1:0]              m_valid,
  output uop_t [NUM_CH-1:0]              m_uop,
  output logic [NUM_CH-1:0][31:0]        m_pc,
  output logic [NUM_CH-1:0][DATA_W-1:0]  m_op1,
  output logic [NUM_CH-1:0][DATA_W-1:0]  m_op2,
  input  logic [NUM_CH-1:0]              m_ready,
  output logic [NUM_CH-1:0][CNT_W-1:0]   m_count
);

  localparam int ENTRY_W = $bits(uop_t) + 32 + 2 * DATA_W;

  logic [NUM_CH-1:0]    full, empty, byp, push;
  logic [2**CH_W-1:0]   full_pad;
  logic                 ch_ok;
  logic [ENTRY_W-1:0]   s_entry;

  assign s_entry = {s_uop, s_pc, s_op1, s_op2};

  always_comb begin
    full_pad = '0;
    full_pad[NUM_CH-1:0] = full;
  end

  // No full-push-through: a same-cycle pop does not reopen a full channel.
  assign ch_ok   = ({1'b0, s_ch} < (CH_W + 1)'(NUM_CH));
  assign s_ready = ch_ok && !flush && !full_pad[s_ch];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ENTRY_W-1:0] head;
    logic               sel;

    assign sel = s_valid && s_ready && (s_ch == CH_W'(i));
`ifdef ISSUE_BYPASS_EN
    assign byp[i] = empty[i] && sel && m_ready[i];
`else
    assign byp[i] = 1'b0;
`endif
    assign push[i] = sel && !byp[i];

    issue_ch_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push[i]),
      .wdata (s_entry),
      .pop   (m_ready[i]),
      .rdata (head),
      .full  (full[i]),
      .empty (empty[i]),
      .count (m_count[i])
    );

    assign m_valid[i] = !empty[i] || byp[i];
    assign {m_uop[i], m_pc[i], m_op1[i], m_op2[i]} =
      !empty[i] ? head : (byp[i] ? s_entry : '0);
  end

  a_ch_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    s_valid |-> ({1'b0, s_ch} < (CH_W + 1)'(NUM_CH)));

endmodule
